arbitro_memoria: RTL and testbench
==================================

# arbitro_memoria

Two-requester round-robin arbiter that shares a single 32-bit memory port between requester 0 (instruction fetch) and requester 1 (data load/store) in the MIPS datapath. It registers the requester choice and drives the 2:1 32-bit select that steers address and write data onto the memory port. It sequences each access for a fixed number of cycles and pulses a per-requester completion strobe with the read data.

## Interface
- LATENCIA, 2, memory access length in cycles; legal range 1..15.
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- req0, req1  in  1  access request from requester 0 / 1.
- addr0, addr1  in  32  access address from requester 0 / 1.
- wdata0, wdata1  in  32  write data from requester 0 / 1.
- we0, we1  in  1  write enable from requester 0 / 1 (0 = read).
- mem_rdata  in  32  read data from memory; valid in the last access cycle.
- sel  out  1  registered select; 0 = requester 0, 1 = requester 1.
- gnt0, gnt1  out  1  grant; high for every cycle of the owner's access.
- done0, done1  out  1  one-cycle completion strobe.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- rdata  out  32  read data returned to requesters; qualified by done0/done1.

## Operation
- FSM states: OCIOSO, ACESSO. Reset value: OCIOSO.
- Registers: sel (reset 0), ultimo (last-served requester, reset 1 so requester 0 wins first tie), contador (4 bits, reset 0).
- OCIOSO: gnt0=gnt1=0, mem_en=0, mem_we=0, done0=done1=0.
  - Only req0 high: sel<=0. Only req1 high: sel<=1. Both high: sel<=~ultimo. Next state: ACESSO, contador<=LATENCIA-1.
  - Neither high: stay in OCIOSO. sel, ultimo and contador hold.
- ACESSO:
  - gnt[sel]=1, mem_en=1.
  - mem_we = we[sel].
  - mem_addr = addr[sel], mem_wdata = wdata[sel]; both are combinational muxes from registered sel.
  - contador≠0: contador decrements.
  - contador==0: done[sel]=1, ultimo<=sel, next state OCIOSO.
- mem_addr and mem_wdata are driven as addr[sel] and wdata[sel] in every state; they are never X after reset.
- rdata = mem_rdata, combinational pass-through. Requesters capture it only on their done strobe.
- Requester contract:
  - Hold req, addr, wdata and we stable from request until its done.
  - To issue another access, keep req high (or reassert it) after done.
- A req drop during ACESSO is ignored: the access completes and done still pulses. Aborting an access is not supported.
- A new request arriving from the non-owner during ACESSO waits; it is arbitrated in the next OCIOSO cycle.
- Reset at any point (including mid-ACESSO):
  - Next cycle: OCIOSO, sel=0, ultimo=1, contador=0.
  - All gnt, done, mem_en and mem_we outputs 0.
  - No done is issued for the aborted access.
- Only one gnt and at most one done are ever high; gnt0 & gnt1 is never 1.

## Timing
- A request sampled high in OCIOSO at edge k produces gnt/mem_en high for cycles k+1 .. k+LATENCIA.
- done[sel] is high in cycle k+LATENCIA, coincident with the last mem_en cycle.
- Each access costs LATENCIA+1 cycles: LATENCIA access cycles plus one OCIOSO arbitration cycle.
- Two requesters held continuously alternate strictly: 0,1,0,1,...
- LATENCIA=1: contador loads 0, and done accompanies the single access cycle.
- Output sources:
  - gnt, mem_en, mem_we and done decode from registered state, sel and contador only. They are glitch-free with respect to req.
  - mem_addr, mem_wdata and rdata are combinational from the inputs.

## Test plan
- Reset, then idle: all outputs 0 except sel=0; mem_addr=addr0. Drive reset=1 mid-ACESSO -> state OCIOSO next cycle, gnt0=gnt1=0, no done pulse.
- Single read with LATENCIA=2: req0=1, addr0=0x0000_0040, we0=0 at edge 0 -> gnt0=1 and mem_en=1 in cycles 1–2, mem_addr=0x40. done0=1 in cycle 2 with rdata=mem_rdata=0xDEAD_BEEF.
- Single write by requester 1: req1=1, addr1=0x1000_0004, wdata1=0x1234_5678, we1=1 -> mem_we=1, mem_wdata=0x1234_5678 for 2 cycles; sel=1; done1 pulses once.
- Simultaneous requests from reset: req0=req1=1 held for 6 accesses -> grant order 0,1,0,1,0,1; each access 3 cycles apart; never gnt0&gnt1.
- Requester 1 asserts during requester 0's access -> requester 0 completes unchanged; requester 1 is granted after one OCIOSO cycle. Also: dropping req0 mid-access still yields done0.
- Parameter sweep LATENCIA=1 and 15 -> done coincides with the 1st / 15th mem_en cycle respectively.

Source files
------------

// File: rtl/arbitro_memoria.sv
// arbitro_memoria: two-requester round-robin arbiter for the shared 32-bit
// memory port (requester 0 = instruction fetch, requester 1 = data access).
// Each access lasts LATENCIA cycles followed by one idle arbitration cycle.
// Grant, enable and done strobes are flops loaded from the next-state
// values, so they depend only on registered state and never glitch with req.
module arbitro_memoria #(
    parameter int unsigned LATENCIA = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] mem_rdata,
    output logic        sel,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [31:0] rdata
);

    typedef enum logic [0:0] {
        OCIOSO = 1'b0,
        ACESSO = 1'b1
    } estado_t;

    // Counter load value: the access runs while contador counts CARGA..0.
    localparam logic [3:0] CARGA = 4'(LATENCIA - 1);

    estado_t     estado_q, estado_d;
    logic        sel_q, sel_d;
    logic        ultimo_q, ultimo_d;
    logic [3:0]  contador_q, contador_d;

    logic        gnt0_q, gnt1_q;
    logic        done0_q, done1_q;
    logic        mem_en_q;

    logic        gnt0_d, gnt1_d;
    logic        done0_d, done1_d;
    logic        mem_en_d;
    logic        em_acesso_d;
    logic        fim_d;

    // Next-state logic: arbitration in OCIOSO, countdown in ACESSO.
    always_comb begin
        estado_d   = estado_q;
        sel_d      = sel_q;
        ultimo_d   = ultimo_q;
        contador_d = contador_q;
        case (estado_q)
            OCIOSO: begin
                if (req0 || req1) begin
                    estado_d   = ACESSO;
                    contador_d = CARGA;
                    if (req0 && req1) begin
                        sel_d = ~ultimo_q;
                    end else begin
                        sel_d = req1;
                    end
                end
            end
            ACESSO: begin
                if (contador_q != 4'd0) begin
                    contador_d = contador_q - 4'd1;
                end else begin
                    ultimo_d = sel_q;
                    estado_d = OCIOSO;
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from next-state values so
    // the flops below present exactly the state-based decode of that cycle.
    always_comb begin
        em_acesso_d = (estado_d == ACESSO);
        fim_d       = em_acesso_d && (contador_d == 4'd0);
        gnt0_d      = em_acesso_d && !sel_d;
        gnt1_d      = em_acesso_d && sel_d;
        done0_d     = fim_d && !sel_d;
        done1_d     = fim_d && sel_d;
        mem_en_d    = em_acesso_d;
    end

    // State, arbitration registers and registered strobes.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            sel_q      <= 1'b0;
            ultimo_q   <= 1'b1;
            contador_q <= '0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            mem_en_q   <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            sel_q      <= sel_d;
            ultimo_q   <= ultimo_d;
            contador_q <= contador_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            mem_en_q   <= mem_en_d;
        end
    end

    // Memory-side steering from the registered select; rdata passes through.
    always_comb begin
        sel       = sel_q;
        gnt0      = gnt0_q;
        gnt1      = gnt1_q;
        done0     = done0_q;
        done1     = done1_q;
        mem_en    = mem_en_q;
        mem_we    = mem_en_q && (sel_q ? we1 : we0);
        mem_addr  = sel_q ? addr1 : addr0;
        mem_wdata = sel_q ? wdata1 : wdata0;
        rdata     = mem_rdata;
    end

endmodule

// File: tb/tb_arbitro_memoria.sv
// tb_arbitro_memoria: directed tests for the round-robin memory arbiter,
// with extra instances at LATENCIA=1 and LATENCIA=15 for the length sweep.
module tb_arbitro_memoria;

    logic        clock;
    logic        reset;
    logic        req0, req1, reqs;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        we0, we1;
    logic [31:0] mem_rdata;

    logic        sel, gnt0, gnt1, done0, done1, mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, rdata;

    logic        a_sel, a_gnt0, a_gnt1, a_done0, a_done1, a_mem_en, a_mem_we;
    logic [31:0] a_mem_addr, a_mem_wdata, a_rdata;
    logic        b_sel, b_gnt0, b_gnt1, b_done0, b_done1, b_mem_en, b_mem_we;
    logic [31:0] b_mem_addr, b_mem_wdata, b_rdata;

    int checks   = 0;
    int failures = 0;

    arbitro_memoria #(.LATENCIA(2)) dut (
        .clock(clock), .reset(reset), .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .we0(we0), .we1(we1), .mem_rdata(mem_rdata),
        .sel(sel), .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .rdata(rdata)
    );

    arbitro_memoria #(.LATENCIA(1)) dut_l1 (
        .clock(clock), .reset(reset), .req0(reqs), .req1(1'b0),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .we0(we0), .we1(we1), .mem_rdata(mem_rdata),
        .sel(a_sel), .gnt0(a_gnt0), .gnt1(a_gnt1), .done0(a_done0), .done1(a_done1),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .rdata(a_rdata)
    );

    arbitro_memoria #(.LATENCIA(15)) dut_l15 (
        .clock(clock), .reset(reset), .req0(reqs), .req1(1'b0),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .we0(we0), .we1(we1), .mem_rdata(mem_rdata),
        .sel(b_sel), .gnt0(b_gnt0), .gnt1(b_gnt1), .done0(b_done0), .done1(b_done1),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .rdata(b_rdata)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled at negedge.
    task automatic tick();
        @(negedge clock);
    endtask

    // Packed view of the strobes: {gnt0, gnt1, done0, done1, mem_en, mem_we}.
    function automatic logic [31:0] strobes();
        return {26'd0, gnt0, gnt1, done0, done1, mem_en, mem_we};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        reqs  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req0      = 1'b0;
        req1      = 1'b0;
        reqs      = 1'b0;
        addr0     = 32'h0000_0A00;
        addr1     = 32'h0000_0B00;
        wdata0    = 32'hAAAA_0000;
        wdata1    = 32'hBBBB_0000;
        we0       = 1'b0;
        we1       = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;

        // Reset and idle
        do_reset();
        tick();
        check("rst_strobes", strobes(), 32'h0);
        check("rst_sel", {31'd0, sel}, 32'd0);
        check("rst_addr", mem_addr, 32'h0000_0A00);
        check("rst_wdata", mem_wdata, 32'hAAAA_0000);
        check("rst_l1_en", {31'd0, a_mem_en}, 32'd0);
        check("rst_l15_en", {31'd0, b_mem_en}, 32'd0);

        // Single read by requester 0
        addr0 = 32'h0000_0040;
        we0   = 1'b0;
        req0  = 1'b1;
        tick();
        check("rd_c1_strobes", strobes(), 32'b100010);
        check("rd_c1_addr", mem_addr, 32'h0000_0040);
        tick();
        check("rd_c2_strobes", strobes(), 32'b101010);
        check("rd_c2_rdata", rdata, 32'hDEAD_BEEF);
        req0 = 1'b0;
        tick();
        check("rd_c3_strobes", strobes(), 32'h0);

        // Single write by requester 1
        addr1  = 32'h1000_0004;
        wdata1 = 32'h1234_5678;
        we1    = 1'b1;
        req1   = 1'b1;
        tick();
        check("wr_c1_sel", {31'd0, sel}, 32'd1);
        check("wr_c1_strobes", strobes(), 32'b010011);
        check("wr_c1_addr", mem_addr, 32'h1000_0004);
        check("wr_c1_wdata", mem_wdata, 32'h1234_5678);
        req1 = 1'b0;
        tick();
        check("wr_c2_strobes", strobes(), 32'b010111);
        check("wr_c2_wdata", mem_wdata, 32'h1234_5678);
        tick();
        check("wr_c3_strobes", strobes(), 32'h0);
        we1 = 1'b0;

        // Both requesters held from reset: strict alternation 0,1,0,1,0,1
        do_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        for (int t = 1; t <= 18; t++) begin
            int          ph;
            int          own;
            logic [31:0] e;
            tick();
            ph  = (t - 1) % 3;
            own = ((t - 1) / 3) % 2;
            if (ph == 2) e = 32'h0;
            else if (own == 0) e = (ph == 1) ? 32'b101010 : 32'b100010;
            else e = (ph == 1) ? 32'b010110 : 32'b010010;
            check($sformatf("rr_t%0d", t), strobes(), e);
            check($sformatf("rr_excl_t%0d", t), {31'd0, gnt0 & gnt1}, 32'd0);
            if (t == 18) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        tick();
        check("rr_end_strobes", strobes(), 32'h0);

        // Requester 1 arrives during requester 0's access; req0 dropped mid-access
        addr0 = 32'h0000_0040;
        addr1 = 32'h2000_0008;
        req0  = 1'b1;
        tick();
        check("cf_c1_strobes", strobes(), 32'b100010);
        req0 = 1'b0;
        req1 = 1'b1;
        tick();
        check("cf_c2_strobes", strobes(), 32'b101010);
        check("cf_c2_addr", mem_addr, 32'h0000_0040);
        tick();
        check("cf_c3_strobes", strobes(), 32'h0);
        tick();
        check("cf_c4_strobes", strobes(), 32'b010010);
        check("cf_c4_addr", mem_addr, 32'h2000_0008);
        req1 = 1'b0;
        tick();
        check("cf_c5_strobes", strobes(), 32'b010110);
        tick();
        check("cf_c6_strobes", strobes(), 32'h0);

        // Reset during requester 1's access
        req1 = 1'b1;
        tick();
        check("ra_c1_sel", {31'd0, sel}, 32'd1);
        check("ra_c1_strobes", strobes(), 32'b010010);
        reset = 1'b1;
        req1  = 1'b0;
        tick();
        check("ra_c2_strobes", strobes(), 32'h0);
        check("ra_c2_sel", {31'd0, sel}, 32'd0);
        check("ra_c2_addr", mem_addr, 32'h0000_0040);
        reset = 1'b0;
        tick();
        check("ra_c3_strobes", strobes(), 32'h0);

        // Length sweep: LATENCIA=1 and LATENCIA=15, request dropped after cycle 1
        reqs = 1'b1;
        for (int t = 1; t <= 16; t++) begin
            tick();
            check($sformatf("l1_en_t%0d", t), {31'd0, a_mem_en}, {31'd0, t == 1});
            check($sformatf("l1_done_t%0d", t), {31'd0, a_done0}, {31'd0, t == 1});
            check($sformatf("l15_en_t%0d", t), {31'd0, b_mem_en}, {31'd0, t <= 15});
            check($sformatf("l15_done_t%0d", t), {31'd0, b_done0}, {31'd0, t == 15});
            reqs = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
